// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes on both sides and status flags
// (zero, neg, carry, ovf, err) registered alongside the result.
// Optional feature macro: ALU_PIPE_MUL_EN. When defined, op 1011 runs an iterative
// shift-add multiplier (IDLE -> MUL_RUN) that stalls the input handshake while it runs.
// When undefined, op 1011 is illegal and the block is a plain one-stage pipeline.
module alu_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpNor  = 4'b0100;
  localparam logic [3:0] OpSltu = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpSll  = 4'b1000;
  localparam logic [3:0] OpSrl  = 4'b1001;
  localparam logic [3:0] OpSra  = 4'b1010;

  logic             accept;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt;
  logic [WIDTH-1:0] res_y;
  logic             res_carry;
  logic             res_ovf;
  logic             res_err;

  logic             load;
  logic [WIDTH-1:0] load_y;
  logic             load_carry;
  logic             load_ovf;
  logic             load_err;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  assign accept = in_valid && in_ready;
  assign shamt  = b[SHW-1:0];

  // Shared adder paths; diff is a + ~b + 1 so its top bit is the "a >= b unsigned" carry.
  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  assign slt     = diff[WIDTH-1] ^ sub_ovf;

`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0]     OpMul   = 4'b1011;
  localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StMulRun} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_step;
  logic             mul_done;
  logic             is_mul;

  assign is_mul   = (select == OpMul);
  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_done = (state_q == StMulRun) && (cnt_q == CntLast);

  // Multiplier FSM: latch operands on accept, then one shift-add step per cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    unique case (state_q)
      StIdle: begin
        if (accept && is_mul) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StMulRun;
        end
      end
      StMulRun: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (mul_done) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Multiplier state register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign load       = (accept && !is_mul) || mul_done;
  assign load_y     = mul_done ? acc_step : res_y;
  assign load_carry = mul_done ? 1'b0 : res_carry;
  assign load_ovf   = mul_done ? 1'b0 : res_ovf;
  assign load_err   = mul_done ? 1'b0 : res_err;
`else
  assign in_ready   = !out_valid_q || out_ready;
  assign load       = accept;
  assign load_y     = res_y;
  assign load_carry = res_carry;
  assign load_ovf   = res_ovf;
  assign load_err   = res_err;
`endif

  // Single-cycle result and flag decode; illegal codes give y = 0 with err set.
  always_comb begin
    res_y     = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    res_err   = 1'b0;
    case (select)
      OpAnd:  res_y = a & b;
      OpOr:   res_y = a | b;
      OpXor:  res_y = a ^ b;
      OpNor:  res_y = ~(a | b);
      OpAdd: begin
        res_y     = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
        res_ovf   = add_ovf;
      end
      OpSub: begin
        res_y     = diff[WIDTH-1:0];
        res_carry = diff[WIDTH];
        res_ovf   = sub_ovf;
      end
      OpSltu: begin
        res_y     = {{(WIDTH-1){1'b0}}, !diff[WIDTH]};
        res_carry = diff[WIDTH];
      end
      OpSlt: begin
        res_y     = {{(WIDTH-1){1'b0}}, slt};
        res_carry = diff[WIDTH];
      end
      OpSll:  res_y = a << shamt;
      OpSrl:  res_y = a >> shamt;
      OpSra:  res_y = $unsigned($signed(a) >>> shamt);
`ifdef ALU_PIPE_MUL_EN
      OpMul:  res_y = '0;  // result comes from the multiplier, not this path
`endif
      default: res_err = 1'b1;
    endcase
  end

  // Output register: hold while stalled, replace on load, drop valid on a bare pop.
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (load) begin
      out_valid_d = 1'b1;
      y_d         = load_y;
      zero_d      = (load_y == '0);
      neg_d       = load_y[WIDTH-1];
      carry_d     = load_carry;
      ovf_d       = load_ovf;
      err_d       = load_err;
    end
  end

  // Output state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe. The driver pushes the expected response
// when an operation is accepted; a monitor pops and compares on every output transfer.
// MUL checks are included when ALU_PIPE_MUL_EN is defined.
module tb_alu_pipe;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] y;
    logic         zero;
    logic         neg;
    logic         carry;
    logic         ovf;
    logic         err;
  } res_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   select = 4'h0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] y;
  logic         zero, neg, carry, ovf, err;

  res_t exp_q[$];
  res_t mon_act, mon_exp;
  int   compared = 0;
  int   mismatched = 0;
  bit   rnd_run = 1'b0;
  bit   bp_done = 1'b0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .select    (select),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference model: the operation table written with wide integer arithmetic.
  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] z);
    res_t r;
    longint unsigned u;
    longint s;
    r = '0;
    case (op)
      4'h0: r.y = x & z;
      4'h1: r.y = x | z;
      4'h2: begin
        u = {32'b0, x} + {32'b0, z};
        r.y = u[31:0];
        r.carry = u[32];
        s = longint'($signed(x)) + longint'($signed(z));
        r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h3: r.y = x ^ z;
      4'h4: r.y = ~(x | z);
      4'h5: begin r.y = (x < z) ? 1 : 0; r.carry = (x >= z); end
      4'h6: begin
        r.y = x - z;
        r.carry = (x >= z);
        s = longint'($signed(x)) - longint'($signed(z));
        r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h7: begin r.y = ($signed(x) < $signed(z)) ? 1 : 0; r.carry = (x >= z); end
      4'h8: r.y = x << (z % W);
      4'h9: r.y = x >> (z % W);
      4'hA: r.y = $signed(x) >>> (z % W);
`ifdef ALU_PIPE_MUL_EN
      4'hB: begin u = {32'b0, x} * {32'b0, z}; r.y = u[31:0]; end
`endif
      default: r.err = 1'b1;
    endcase
    r.zero = (r.y == 0);
    r.neg  = r.y[W-1];
    return r;
  endfunction

  function automatic res_t mk(input logic [W-1:0] yy, input logic zz, input logic nn,
                              input logic cc, input logic vv, input logic ee);
    res_t r;
    r.y = yy; r.zero = zz; r.neg = nn; r.carry = cc; r.ovf = vv; r.err = ee;
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Offer one op, push its expected response on the accepting edge; returns #1 after it.
  task automatic issue_exp(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                           input res_t e);
    int  n = 0;
    bit  done = 1'b0;
    select = op; a = aa; b = bb; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end else if (++n > 500) begin
        compared++; mismatched++;
        $display("FAIL accept_timeout: op %h not accepted in 500 cycles, required acceptance", op);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb);
    issue_exp(op, aa, bb, model(op, aa, bb));
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 2000) begin @(posedge clk); n++; end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      mon_act = {y, zero, neg, carry, ovf, err};
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL result: unexpected output y=%h, required no output", y);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          mismatched++;
          $display("FAIL result: got y=%h z%b n%b c%b v%b e%b, required y=%h z%b n%b c%b v%b e%b",
                   mon_act.y, mon_act.zero, mon_act.neg, mon_act.carry, mon_act.ovf, mon_act.err,
                   mon_exp.y, mon_exp.zero, mon_exp.neg, mon_exp.carry, mon_exp.ovf, mon_exp.err);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    compared++; mismatched++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    logic bad_ready, bad_valid;

    // Reset held for two edges with an op offered.
    reset_n = 1'b0; in_valid = 1'b1; select = 4'h2; a = 1; b = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_y", y, 0);
    check("reset_err", err, 0);
    check("reset_flags", {zero, neg, carry, ovf}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed arithmetic, compare and shift cases.
    issue_exp(4'h2, 32'hFFFF_FFFF, 32'h1, mk(32'h0, 1, 0, 1, 0, 0));
    issue_exp(4'h2, 32'h7FFF_FFFF, 32'h1, mk(32'h8000_0000, 0, 1, 0, 1, 0));
    issue_exp(4'h6, 32'h3, 32'h5, mk(32'hFFFF_FFFE, 0, 1, 0, 0, 0));
    issue_exp(4'h7, 32'hFFFF_FFFF, 32'h1, mk(32'h1, 0, 0, 1, 0, 0));
    issue_exp(4'h5, 32'hFFFF_FFFF, 32'h1, mk(32'h0, 1, 0, 1, 0, 0));
    issue_exp(4'hA, 32'h8000_0000, 32'h21, mk(32'hC000_0000, 0, 1, 0, 0, 0));
    drain();

    // Illegal op: single-cycle latency with err set.
    issue_exp(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, mk(32'h0, 1, 0, 0, 0, 1));
    check("illegal_latency", out_valid, 1);
    check("illegal_err", {y, err, zero}, {32'h0, 1'b1, 1'b1});
    drain();

`ifdef ALU_PIPE_MUL_EN
    // MUL: WIDTH cycles of latency with in_ready low until the result loads.
    issue_exp(4'hB, 32'h0001_0003, 32'h0000_0005, mk(32'h0005_000F, 0, 0, 0, 0, 0));
    bad_ready = 1'b0; bad_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0) bad_ready = 1'b1;
      if (out_valid !== 1'b0) bad_valid = 1'b1;
      @(posedge clk);
    end
    check("mul_in_ready_low", bad_ready, 0);
    check("mul_no_early_valid", bad_valid, 0);
    @(negedge clk);
    check("mul_latency", out_valid, 1);
    @(posedge clk); #1;
    drain();

    // Reset in the 10th cycle of a MUL abandons it.
    issue(4'hB, 32'hDEAD_BEEF, 32'h1234_5677);
    repeat (9) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mul_reset_in_ready", in_ready, 1);
    bad_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad_valid = 1'b1;
    end
    check("mul_reset_no_result", bad_valid, 0);
    @(posedge clk); #1;
`else
    issue_exp(4'hB, 32'h0001_0003, 32'h0000_0005, mk(32'h0, 1, 0, 0, 0, 1));
    check("op1011_latency", out_valid, 1);
    check("op1011_err", {y, err, zero}, {32'h0, 1'b1, 1'b1});
    drain();
    bad_ready = 1'b0; bad_valid = 1'b0;
`endif

    // Back-pressure: three back-to-back ADDs with out_ready low for four cycles.
    out_ready = 1'b0; bp_done = 1'b0;
    fork
      begin
        issue(4'h2, 32'h1, 32'h1);
        issue(4'h2, 32'h2, 32'h2);
        issue(4'h2, 32'h3, 32'h3);
        bp_done = 1'b1;
      end
    join_none
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", {out_valid, y}, {1'b1, 32'h2});
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    for (int n = 0; n < 100 && !bp_done; n++) @(posedge clk);
    check("bp_all_accepted", bp_done, 1);
    drain();

    // Randomized ops against the model with random output stalls.
    rnd_run = 1'b1;
    fork
      while (rnd_run) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick());
      if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
    end
    rnd_run = 1'b0;
    @(posedge clk); #1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
